// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
// Operand helpers work on a MAX_W-bit container and are truncated by the caller.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam int MAX_W = 64;

  function automatic int calc_n(input int width, input int bpc);
    return width / bpc;
  endfunction

  // Magnitude of a width-bit operand held zero-extended in MAX_W bits.
  // The most-negative value maps to 2^(width-1), which still fits in width bits.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] value,
                                               input logic             signed_mode,
                                               input int               width);
    logic [MAX_W-1:0] mask;
    logic             sign;
    mask = {MAX_W{1'b1}} >> (MAX_W - width);
    sign = |(value & (MAX_W'(1) << (width - 1)));
    if (signed_mode && sign) begin
      return (~value + MAX_W'(1)) & mask;
    end
    return value & mask;
  endfunction

endpackage

// File: rtl/mult_pp_gen.sv
// Partial product of the multiplicand magnitude and BITS_PER_CYCLE multiplier bits.
// Purely combinational; keeps the radix choice out of the FSM and accumulator.
module mult_pp_gen #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0]                mag_a_i,
  input  logic [BITS_PER_CYCLE-1:0]       bits_i,
  output logic [WIDTH+BITS_PER_CYCLE-1:0] pp_o
);

  always_comb begin
    pp_o = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (bits_i[i]) begin
        pp_o = pp_o + ({{BITS_PER_CYCLE{1'b0}}, mag_a_i} << i);
      end
    end
  end

endmodule

// File: rtl/mult_shift_add_seq.sv
// Sequential shift-and-add multiplier, signed/unsigned, valid/ready in, one-cycle out_valid pulse.
// Latency N+1 (N = WIDTH/BITS_PER_CYCLE); MULT_SHIFT_ADD_SEQ_EARLY_TERM_EN stops once the multiplier drains.
module mult_shift_add_seq
  import mult_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   p
);

  localparam int N  = calc_n(WIDTH, BITS_PER_CYCLE);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e                          state_q;
  logic [WIDTH-1:0]                mag_a_q;
  logic [WIDTH-1:0]                mplr_q;
  logic                            neg_q;
  logic [2*WIDTH-1:0]              acc_q;
  logic [2*WIDTH-1:0]              p_q;
  logic [CW-1:0]                   cnt_q;
  logic                            out_valid_q;

  logic [WIDTH-1:0]                mag_a_d;
  logic [WIDTH-1:0]                mag_b_d;
  logic                            neg_d;
  logic [WIDTH+BITS_PER_CYCLE-1:0] pp;
  logic [2*WIDTH-1:0]              acc_d;
  logic [WIDTH-1:0]                mplr_d;
  logic                            last_iter;

  assign mag_a_d = WIDTH'(abs_val(MAX_W'(a), signed_mode, WIDTH));
  assign mag_b_d = WIDTH'(abs_val(MAX_W'(b), signed_mode, WIDTH));
  assign neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

  mult_pp_gen #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_pp_gen (
    .mag_a_i (mag_a_q),
    .bits_i  (mplr_q[BITS_PER_CYCLE-1:0]),
    .pp_o    (pp)
  );

  // Partial product lands at bit cnt*BITS_PER_CYCLE of the accumulator.
  always_comb begin
    acc_d     = acc_q + ({{(WIDTH-BITS_PER_CYCLE){1'b0}}, pp} << (int'(cnt_q) * BITS_PER_CYCLE));
    mplr_d    = mplr_q >> BITS_PER_CYCLE;
    last_iter = (cnt_q == CW'(N - 1));
`ifdef MULT_SHIFT_ADD_SEQ_EARLY_TERM_EN
    last_iter = last_iter | (mplr_d == '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_a_q     <= '0;
      mplr_q      <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (in_valid) begin
            mag_a_q <= mag_a_d;
            mplr_q  <= mag_b_d;
            neg_q   <= neg_d;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef MULT_SHIFT_ADD_SEQ_EARLY_TERM_EN
            if (mag_b_d == '0) begin
              state_q     <= FIX;
              out_valid_q <= 1'b1;
              p_q         <= '0;
            end else begin
              state_q <= CALC;
            end
`else
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          acc_q  <= acc_d;
          mplr_q <= mplr_d;
          cnt_q  <= cnt_q + CW'(1);
          // Product is registered on the way into FIX so p is valid alongside out_valid.
          if (last_iter) begin
            state_q     <= FIX;
            out_valid_q <= 1'b1;
            p_q         <= neg_q ? ('0 - acc_d) : acc_d;
          end
        end
        FIX: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC) || (state_q == FIX);
  assign out_valid = out_valid_q;
  assign p         = p_q;

endmodule

// File: tb/tb_mult_shift_add_seq.sv
// Self-checking bench: directed corners plus random operands on BPC=1/2/4 instances.
// Expected products and latencies come from a plain-arithmetic reference model.
module tb_mult_shift_add_seq;

  localparam int W = 32;
`ifdef MULT_SHIFT_ADD_SEQ_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, signed_mode;
  logic [W-1:0]  a, b;
  logic          in_ready, out_valid, busy;
  logic [2*W-1:0] p;

  logic          x_valid, x_sm;
  logic [W-1:0]  x_a, x_b;
  logic          x2_ready, x2_ov, x2_busy, x4_ready, x4_ov, x4_busy;
  logic [2*W-1:0] x2_p, x4_p;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] prev_p;
  bit          ov_seen;

  mult_shift_add_seq #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .a(a), .b(b),
    .out_valid(out_valid), .busy(busy), .p(p));

  mult_shift_add_seq #(.WIDTH(W), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x2_ready),
    .signed_mode(x_sm), .a(x_a), .b(x_b),
    .out_valid(x2_ov), .busy(x2_busy), .p(x2_p));

  mult_shift_add_seq #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x4_ready),
    .signed_mode(x_sm), .a(x_a), .b(x_b),
    .out_valid(x4_ov), .busy(x4_busy), .p(x4_p));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] av, input logic [31:0] bv);
    longint x, y;
    x = s ? longint'($signed(av)) : longint'({32'd0, av});
    y = s ? longint'($signed(bv)) : longint'({32'd0, bv});
    return 64'(x * y);
  endfunction

  function automatic int model_lat(input logic s, input logic [31:0] bv, input int bpc);
    logic [31:0] m;
    int          msb;
    m   = (s && bv[31]) ? (32'd0 - bv) : bv;
    msb = -1;
    for (int i = 0; i < 32; i++) if (m[i]) msb = i;
    if (EARLY && m == 0) return 1;
    if (EARLY) return (msb + bpc) / bpc + 1;
    return 32 / bpc + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic run_op(input logic s, input logic [31:0] av, input logic [31:0] bv, input string tag);
    logic [63:0] ep;
    int el, lat, bcnt, rcnt;
    bit got;
    ep = ref_prod(s, av, bv);
    el = model_lat(s, bv, 1);
    @(negedge clk);
    in_valid = 1'b1; signed_mode = s; a = av; b = bv;
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; signed_mode = ~s; a = $urandom; b = $urandom;
    lat = 0; bcnt = 0; rcnt = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (in_ready) rcnt++;
      if (out_valid) got = 1'b1;
      else chk({tag, "_pstable"}, p, prev_p);
    end
    chk({tag, "_lat"}, 64'(lat), 64'(el));
    chk({tag, "_p"}, p, ep);
    chk({tag, "_busycyc"}, 64'(bcnt), 64'(el));
    chk({tag, "_rdylow"}, 64'(rcnt), 64'd0);
    @(negedge clk);
    chk({tag, "_ovpulse"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle"}, 64'(in_ready), 64'd1);
    chk({tag, "_phold"}, p, ep);
    prev_p = ep;
  endtask

  task automatic run_pair(input logic s, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] ep, p2, p4;
    int lat, l2, l4;
    ep = ref_prod(s, av, bv);
    @(negedge clk);
    x_valid = 1'b1; x_sm = s; x_a = av; x_b = bv;
    chk("t3_rdy", 64'({x2_ready, x4_ready}), 64'd3);
    @(posedge clk); #1;
    x_valid = 1'b0; x_a = $urandom; x_b = $urandom; x_sm = ~s;
    lat = 0; l2 = 0; l4 = 0; p2 = '0; p4 = '0;
    while ((l2 == 0 || l4 == 0) && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("t3_busy", 64'({x2_busy, x4_busy}), 64'd3);
      if (x2_ov && l2 == 0) begin l2 = lat; p2 = x2_p; end
      if (x4_ov && l4 == 0) begin l4 = lat; p4 = x4_p; end
    end
    chk("t3_lat2", 64'(l2), 64'(model_lat(s, bv, 2)));
    chk("t3_p2", p2, ep);
    chk("t3_lat4", 64'(l4), 64'(model_lat(s, bv, 4)));
    chk("t3_p4", p4, ep);
    @(negedge clk);
  endtask

  task automatic run_stream(input int nops);
    int nxt, due, nacc, nres;
    bit pend, rdy;
    logic [63:0] pexp;
    logic sv;
    logic [31:0] av, bv;
    nxt = 0; due = 0; nacc = 0; nres = 0; pend = 1'b0; pexp = '0;
    for (int k = 0; k < 400 && nres < nops; k++) begin
      @(negedge clk);
      rdy = (k >= nxt);
      chk("t4_rdy", 64'(in_ready), 64'(rdy));
      if (pend && k == due) begin
        chk("t4_ov", 64'(out_valid), 64'd1);
        chk("t4_p", p, pexp);
        prev_p = pexp; pend = 1'b0; nres++;
      end else begin
        chk("t4_ovlow", 64'(out_valid), 64'd0);
        chk("t4_pstable", p, prev_p);
      end
      sv = 1'($urandom); av = pick(); bv = pick();
      in_valid = (nacc < nops); signed_mode = sv; a = av; b = bv;
      if (rdy && nacc < nops) begin
        pexp = ref_prod(sv, av, bv);
        due  = k + model_lat(sv, bv, 1);
        nxt  = due + 1;
        pend = 1'b1;
        nacc++;
      end
    end
    in_valid = 1'b0;
    chk("t4_count", 64'(nres), 64'(nops));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    x_valid = 1'b0; x_sm = 1'b0; x_a = '0; x_b = '0;
    prev_p = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_p", p, 64'd0);
    chk("rst_p24", {x2_p[31:0], x4_p[31:0]}, 64'd0);
    rst_n = 1'b1;

    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t1_uu");
    chk("t1_const", p, 64'hFFFF_FFFE_0000_0001);
    run_op(1'b1, 32'hFFFF_FFFD, 32'd5, "t2_m3x5");
    chk("t2_m3x5_const", p, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, "t2_minmin");
    chk("t2_minmin_const", p, 64'h4000_0000_0000_0000);
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2_m1m1");
    chk("t2_m1m1_const", p, 64'd1);

    run_op(1'b0, 32'd5, 32'd3, "t6_5x3");
    chk("t6_5x3_const", p, 64'd15);
    run_op(1'b0, 32'h1234_5678, 32'd0, "t6_bzero");
    run_op(1'b1, 32'hFFFF_FFF0, 32'd0, "t6_negbzero");
    run_op(1'b0, 32'd9, 32'h8000_0000, "t6_bmsb");

    for (int i = 0; i < 20; i++) run_op(1'($urandom), pick(), pick(), "t1_rand");

    run_stream(4);

    // Abort a long operation part-way through, then restart cleanly.
    @(negedge clk);
    in_valid = 1'b1; signed_mode = 1'b0; a = $urandom; b = 32'($urandom) | 32'h8000_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_ov", 64'(out_valid), 64'd0);
    chk("t5_p", p, 64'd0);
    chk("t5_rdy", 64'(in_ready), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    ov_seen = 1'b0;
    in_valid = 1'b1; a = 32'd7; b = 32'd6;
    repeat (3) begin
      @(negedge clk);
      ov_seen = ov_seen | out_valid | busy;
    end
    chk("t5_noactivity", 64'(ov_seen), 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    prev_p = '0;
    run_op(1'b0, 32'd7, 32'd6, "t5_restart");
    chk("t5_42", p, 64'd42);

    for (int i = 0; i < 300; i++) run_pair(1'(i % 2), pick(), pick());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_shift_add_seq.md
Name: mult_shift_add_seq

Overview:
Parametrised sequential shift-and-add multiplier. Next generation of the 32-bit unsigned shift-add multiplier: configurable width and bits retired per cycle, per-operation signed/unsigned mode, and a valid/ready handshake. It sits between the register/control path and datapath consumers as a low-area multiply engine.

Parameters:
WIDTH, 32, operand width in bits (>=4, even)
BITS_PER_CYCLE, 1, multiplier bits retired per CALC cycle; legal values 1, 2, 4; must divide WIDTH
N (localparam), WIDTH/BITS_PER_CYCLE, number of CALC iterations

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  high when the engine accepts a request (state IDLE)
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept
a  in  WIDTH  multiplicand; sampled at accept
b  in  WIDTH  multiplier; sampled at accept
out_valid  out  1  one-cycle pulse; p is valid while it is high
busy  out  1  high in CALC and FIX
p  out  2*WIDTH  product; held until the next accept

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, in_ready=1, out_valid=0, busy=0, p=0, all internal registers=0.
- States:
  - IDLE: in_ready=1. Accept = in_valid & in_ready at a rising edge. On accept:
    - latch mag_a=|a| and mag_b=|b| (plain value when signed_mode=0);
    - latch neg = signed_mode & (a[MSB]^b[MSB]);
    - clear the accumulator; go to CALC.
  - CALC: each cycle, take the low BITS_PER_CYCLE bits of the multiplier register, form the partial product (mag_a * those bits), add it into the accumulator at the current shift, then shift the multiplier right by BITS_PER_CYCLE. After N cycles go to FIX.
  - FIX: p <= neg ? -acc : acc (2*WIDTH two's-complement negate); out_valid=1 this cycle; next state IDLE.
- Latency: out_valid is high during the (N+1)th cycle after the accept edge.
  - WIDTH=32, BPC=1: 33 cycles.
  - WIDTH=32, BPC=2: 17 cycles.
- Throughput: one operation per N+2 cycles. in_ready is low in CALC and FIX; in_valid is ignored there (no queueing). A new accept is possible in the cycle after out_valid.
- Magnitude of the most-negative operand (e.g. 0x80000000) is 2^(WIDTH-1). Hold magnitudes in WIDTH bits, unsigned; no overflow is possible. The accumulator is 2*WIDTH bits and never overflows.
- p changes only in FIX and on reset. It is stable while IDLE and during the next operation's CALC.
- Reset mid-operation: immediately abort to IDLE. No out_valid; p=0.
- in_valid and rst_n deassertion in the same cycle: the request is not accepted until the first edge with rst_n high.

Optional Feature:
- Macro: MULT_SHIFT_ADD_SEQ_EARLY_TERM_EN.
- When defined: leave CALC for FIX as soon as the shifted multiplier register becomes zero after an iteration. If mag_b==0 at accept, go from IDLE directly to FIX (out_valid one cycle after the accept edge). Latency is data-dependent: ceil((msb_index(mag_b)+1)/BITS_PER_CYCLE)+1.
- When not defined: fixed N+1 latency.
- Product value is identical in both builds.

Decomposition:
- Shared package mult_pkg:
  - state enum (IDLE, CALC, FIX);
  - localparam helper for N;
  - function abs_val(value, signed_mode).
- One natural sub-module: mult_pp_gen. It is combinational and produces the (WIDTH+BITS_PER_CYCLE)-bit partial product of mag_a × BITS_PER_CYCLE multiplier bits. This isolates the radix choice from the FSM/accumulator.

Test Plan:
1. WIDTH=32, BPC=1, unsigned, a=b=0xFFFFFFFF, in_valid pulse → out_valid exactly 33 cycles after accept, p=0xFFFFFFFE00000001; busy high for 33 cycles; in_ready low throughout.
2. Signed, a=0xFFFFFFFD (-3), b=5 → p=0xFFFFFFFFFFFFFFF1. Signed, a=b=0x80000000 → p=0x4000000000000000. Signed, a=b=0xFFFFFFFF → p=1.
3. BPC=2 and BPC=4 builds, random 1000 operand pairs, both modes → p matches the reference product. Latency 17 and 9 cycles respectively.
4. Hold in_valid high continuously with distinct a/b per cycle → only operands present at IDLE accept edges are used. Back-to-back results spaced N+2 cycles apart; p is stable between out_valid pulses.
5. Assert rst_n=0 at iteration 10 of a 32-bit operation → out_valid never pulses, p=0, in_ready=1 immediately. A new operation (a=7, b=6) after release → p=42.
6. MULT_SHIFT_ADD_SEQ_EARLY_TERM_EN defined, BPC=1:
   - a=5, b=3 → p=15, out_valid 3 cycles after accept;
   - b=0 → p=0 after 1 cycle;
   - b=0x80000000 unsigned → full 33 cycles.
